// File: rtl/apb_arbiter_2to1_pkg.sv
// Shared types and constants for the two-master APB arbiter.
package apb_arbiter_2to1_pkg;

  localparam int ARB_NPORTS = 2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2
  } arb_state_t;

  typedef logic [ARB_NPORTS-1:0] arb_req_t;

endpackage

// File: rtl/apb_arbiter_2to1_if.sv
// APB bus bundle; "master" drives address/control, "slave" drives the response.
interface apb_arbiter_2to1_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_arbiter_2to1_pick.sv
// Combinational winner select for the 2:1 APB arbiter.
// APB_ARB_RR_EN selects round-robin on ties; otherwise port 1 has fixed priority.
module apb_arb_pick
  import apb_arbiter_2to1_pkg::*;
(
  input  arb_req_t req_i,
  input  logic     last_grant_i,
  output logic     valid_o,
  output logic     grant_o
);

  assign valid_o = |req_i;

`ifdef APB_ARB_RR_EN
  always_comb begin
    grant_o = req_i[1];
    // On a tie, hand the bus to whichever port did not win last time.
    if (&req_i) begin
      grant_o = ~last_grant_i;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign grant_o           = req_i[1];
`endif

endmodule

// File: rtl/apb_arbiter_2to1.sv
// Shares one downstream APB slave between a fetch port (s0) and a data port (s1).
// Tie policy: APB_ARB_RR_EN defined -> round-robin, undefined -> port 1 fixed priority.
module apb_arbiter_2to1
  import apb_arbiter_2to1_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  apb_arbiter_2to1_if.slave         s0,
  apb_arbiter_2to1_if.slave         s1,
  apb_arbiter_2to1_if.master        m
);

  localparam logic [1:0] ST_IDLE   = ARB_IDLE;
  localparam logic [1:0] ST_SETUP  = ARB_SETUP;
  localparam logic [1:0] ST_ACCESS = ARB_ACCESS;

  logic [1:0]            state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;
  logic [DATA_W/8-1:0]   pstrb_q, pstrb_d;
  logic                  pwrite_q, pwrite_d;

  arb_req_t              req;
  logic                  pick_valid;
  logic                  pick_grant;
  logic                  rsp_valid;
  logic                  unused_penable;

  assign req            = {s1.psel, s0.psel};
  assign unused_penable = s0.penable ^ s1.penable;

  apb_arb_pick u_pick (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .grant_o      (pick_grant)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    pwrite_d     = pwrite_q;
    case (state_q)
      ST_IDLE: begin
        // Capture the winner's command here so upstream changes cannot leak downstream.
        if (pick_valid) begin
          state_d      = ST_SETUP;
          grant_d      = pick_grant;
          last_grant_d = pick_grant;
          paddr_d      = pick_grant ? s1.paddr  : s0.paddr;
          pwdata_d     = pick_grant ? s1.pwdata : s0.pwdata;
          pstrb_d      = pick_grant ? s1.pstrb  : s0.pstrb;
          pwrite_d     = pick_grant ? s1.pwrite : s0.pwrite;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (m.pready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      pwrite_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      pwrite_q     <= pwrite_d;
    end
  end

  assign m.psel    = (state_q != ST_IDLE);
  assign m.penable = (state_q == ST_ACCESS);
  assign m.paddr   = paddr_q;
  assign m.pwdata  = pwdata_q;
  assign m.pstrb   = pstrb_q;
  assign m.pwrite  = pwrite_q;

  // The response is steered only to the granted port and only in its completion cycle.
  assign rsp_valid  = (state_q == ST_ACCESS) && m.pready;

  assign s0.pready  = rsp_valid && !grant_q;
  assign s0.pslverr = rsp_valid && !grant_q && m.pslverr;
  assign s0.prdata  = (rsp_valid && !grant_q) ? m.prdata : '0;

  assign s1.pready  = rsp_valid && grant_q;
  assign s1.pslverr = rsp_valid && grant_q && m.pslverr;
  assign s1.prdata  = (rsp_valid && grant_q) ? m.prdata : '0;

`ifndef SYNTHESIS
  logic granted_psel;
  assign granted_psel = grant_q ? s1.psel : s0.psel;

  // A master abandoning its transfer still lets the downstream cycle finish.
  always_ff @(posedge clk) begin
    if (!rst && (state_q != ST_IDLE)) begin
      assert (granted_psel)
        else $error("apb_arbiter_2to1: granted psel dropped before pready");
    end
  end
`endif

endmodule

// File: doc/apb_arbiter_2to1.md
Name: apb_arbiter_2to1

Overview:
- Shares one downstream APB slave (unified instruction/data memory) between two upstream APB masters.
- Port 0 is the core instruction-fetch APB; port 1 is the core data APB.
- Accepts one upstream transfer at a time, replays it on the downstream bus and returns the response to the granted requester.
- Stalls the other requester by holding its pready low.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width; pstrb is DATA_W/8 bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s0_psel, s0_penable, s0_pwrite  in  1 each  port 0 (fetch) APB control.
- s0_paddr  in  ADDR_W  port 0 address.
- s0_pwdata  in  DATA_W  port 0 write data.
- s0_pstrb  in  DATA_W/8  port 0 byte strobes.
- s0_prdata  out  DATA_W  port 0 read data.
- s0_pready, s0_pslverr  out  1 each  port 0 response.
- s1_*  same set as s0_*  port 1 (data).
- m_psel, m_penable, m_pwrite  out  1 each  downstream APB control.
- m_paddr  out  ADDR_W  downstream address.
- m_pwdata  out  DATA_W  downstream write data.
- m_pstrb  out  DATA_W/8  downstream byte strobes.
- m_prdata  in  DATA_W  downstream read data.
- m_pready, m_pslverr  in  1 each  downstream response.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous, active-high.
- On reset:
  - state = IDLE, grant = 0, m_psel = 0, m_penable = 0.
  - m_paddr, m_pwdata, m_pstrb, m_pwrite = 0.
  - s0/s1 pready = 0, prdata = 0, pslverr = 0.
- Request: port n requests when sn_psel = 1 (penable is ignored for arbitration).
- State machine, type arb_state_t:
  - IDLE: if any request, select a winner, latch its paddr/pwrite/pwdata/pstrb into the m_* registers and record grant → SETUP. Otherwise stay in IDLE.
  - SETUP: m_psel = 1, m_penable = 0 → ACCESS unconditionally.
  - ACCESS: m_psel = 1, m_penable = 1. Hold while m_pready = 0. On m_pready = 1 → IDLE.
- Response path:
  - Combinational: s<grant>_pready = m_pready & (state == ACCESS).
  - s<grant>_prdata = m_prdata and s<grant>_pslverr = m_pslverr in that cycle.
  - Non-granted port: pready = 0, pslverr = 0, prdata = 0.
- Latency: request sampled in cycle t, downstream SETUP in t+1, ACCESS from t+2. With a zero-wait slave, upstream pready is seen in t+2. Minimum 3 cycles per transfer; the IDLE bubble is mandatory, so there are no back-to-back grants.
- Downstream address/control/data are registered at grant and held stable through SETUP/ACCESS regardless of upstream changes.
- Simultaneous requests in IDLE resolve by the arbitration policy (see Optional Feature). The loser's request stays pending with pready = 0 and wins next IDLE unless preempted under fixed priority.
- Upstream protocol violation (granted sn_psel dropping before its pready): downstream transfer completes normally and the response is discarded. Flagged by a simulation assertion.
- rst asserted mid-transfer: immediate return to reset values next edge. The in-flight transfer is abandoned and m_psel drops.

Optional Feature:
- Macro APB_ARB_RR_EN.
- Defined: round-robin. On a tie in IDLE, grant the port not granted last; a last_grant register resets to 1, so port 0 wins the first tie.
- Undefined: fixed priority, port 1 (data) always wins ties; port 0 can starve under continuous data traffic.

Decomposition:
- typedefs package: arb_state_t enum {ARB_IDLE, ARB_SETUP, ARB_ACCESS}.
- typedefs package: ARB_NPORTS = 2 constant.
- One sub-module, apb_arb_pick: combinational winner select from req[1:0] and last_grant, with the policy chosen by APB_ARB_RR_EN.

Test Plan:
- Single read on port 0: s0_paddr = 0x40, slave returns 0xDEADBEEF with 0 waits → m_psel rises cycle t+1, m_penable t+2; s0_pready = 1 with s0_prdata = 0xDEADBEEF at t+2; s1_pready stays 0.
- Write on port 1 with waits: s1_paddr = 0x100, s1_pwdata = 0x12345678, s1_pstrb = 0x3, slave inserts 3 wait cycles → m_* hold those values for 4 ACCESS cycles; s1_pready pulses once.
- Simultaneous requests, macro undefined: port 1 granted first; port 0 granted in the following IDLE; each completes once. Repeating port 1 requests starve port 0.
- Simultaneous requests, APB_ARB_RR_EN defined, repeated 4 times → grants alternate 0,1,0,1,…
- Slave error: m_pslverr = 1 with m_pready on a port 0 read → s0_pslverr = 1 for exactly that cycle; s1_pslverr stays 0.
- Reset mid-ACCESS with m_pready = 0 → next cycle m_psel = 0, state IDLE, all pready = 0; a fresh request afterward is served normally.
